// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - size encodings, FSM states and strobe helper shared by the APB master
package apb_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10,
    RESP   = 2'b11
  } apb_state_e;

  // Lane strobes for a request of the given size at byte offset within the word
  function automatic logic [3:0] gen_strobe(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] stb;
    case (size)
      SZ_BYTE: stb = 4'b0001 << offset;
      SZ_HALF: stb = 4'b0011 << offset;
      SZ_WORD: stb = 4'b1111;
      default: stb = 4'b0000;
    endcase
    return stb;
  endfunction

endpackage

// File: rtl/apb_lane_align.sv
// rtl/apb_lane_align.sv - byte-lane placement of store data and extraction/extension of load data
module apb_lane_align
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            offset,
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  output logic [3:0]            strobe,
  output logic [DATA_WIDTH-1:0] lane_wdata,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  misaligned
);

  logic [DATA_WIDTH-1:0] byte_mask;
  logic [DATA_WIDTH-1:0] shifted_w;
  logic [DATA_WIDTH-1:0] shifted_r;
  logic                  sext;

  always_comb begin
    strobe     = gen_strobe(size, offset);
    misaligned = (size == SZ_RSVD) ||
                 ((size == SZ_HALF) && offset[0]) ||
                 ((size == SZ_WORD) && (offset != 2'b00));

    byte_mask = '0;
    for (int i = 0; i < 4; i++) begin
      byte_mask[8*i +: 8] = {8{strobe[i]}};
    end

    // Store data is right-justified; bytes above the access size must not leak onto the bus
    shifted_w  = wdata << {offset, 3'b000};
    lane_wdata = shifted_w & byte_mask;

    shifted_r = prdata >> {offset, 3'b000};
    sext      = !is_unsigned;
    case (size)
      SZ_BYTE: load_data = {{(DATA_WIDTH-8){sext & shifted_r[7]}}, shifted_r[7:0]};
      SZ_HALF: load_data = {{(DATA_WIDTH-16){sext & shifted_r[15]}}, shifted_r[15:0]};
      default: load_data = shifted_r;
    endcase
  end

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - single-outstanding APB initiator for load/store requests with timeout
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  prst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [3:0]            pstb,
  input  logic                  pready,
  input  logic                  perr
);

  localparam int CW = $clog2(TIMEOUT + 1);

  apb_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [1:0]            size_q, size_d;
  logic                  unsigned_q, unsigned_d;
  logic                  req_ready_q, req_ready_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic [3:0]            pstb_q, pstb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [1:0]            al_offset;
  logic [1:0]            al_size;
  logic                  al_unsigned;
  logic [3:0]            al_strobe;
  logic [DATA_WIDTH-1:0] al_wdata;
  logic [DATA_WIDTH-1:0] al_load;
  logic                  al_misaligned;

  // In IDLE the aligner sees the incoming request; afterwards it sees the registered one for load data
  always_comb begin
    if (state_q == IDLE) begin
      al_offset   = req_addr[1:0];
      al_size     = req_size;
      al_unsigned = req_unsigned;
    end else begin
      al_offset   = paddr_q[1:0];
      al_size     = size_q;
      al_unsigned = unsigned_q;
    end
  end

  apb_lane_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .offset      (al_offset),
    .size        (al_size),
    .is_unsigned (al_unsigned),
    .wdata       (req_wdata),
    .prdata      (prdata),
    .strobe      (al_strobe),
    .lane_wdata  (al_wdata),
    .load_data   (al_load),
    .misaligned  (al_misaligned)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    unsigned_d  = unsigned_q;
    req_ready_d = req_ready_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pdata_d     = pdata_q;
    pstb_d      = pstb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          size_d      = req_size;
          unsigned_d  = req_unsigned;
          if (al_misaligned) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d   = SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = req_write;
            paddr_d   = req_addr;
            pdata_d   = al_wdata;
            pstb_d    = al_strobe;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: begin
        if (pready) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = perr;
          rsp_rdata_d = (perr || pwrite_q) ? '0 : al_load;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Last allowed ACCESS cycle ended without pready: abandon the transfer
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      size_q      <= SZ_BYTE;
      unsigned_q  <= 1'b0;
      req_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pdata_q     <= '0;
      pstb_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      unsigned_q  <= unsigned_d;
      req_ready_q <= req_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pdata_q     <= pdata_d;
      pstb_q      <= pstb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pdata     = pdata_q;
  assign pstb      = pstb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - self-checking bench for apb_master with an SRAM-like responder
module tb_apb_master;
  import apb_pkg::*;

  logic        pclk = 1'b0;
  logic        prst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] paddr;
  logic [31:0] pdata;
  logic [31:0] prdata;
  logic        psel, penable, pwrite;
  logic [3:0]  pstb;
  logic        pready, perr;

  int n_chk = 0;
  int n_fail = 0;

  always #5 pclk = ~pclk;

  apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .pclk(pclk), .prst(prst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pdata(pdata), .prdata(prdata), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pstb(pstb), .pready(pready), .perr(perr)
  );

  // Responder: mode 0 normal, 1 never ready, 2 error; pready after 'delay' sampled penable cycles
  int          mode = 0;
  int          delay = 1;
  int          rcnt;
  logic        pready_r;
  logic [31:0] sram [0:63];

  always @(posedge pclk) begin
    if (prst) begin
      pready_r <= 1'b0;
      rcnt     <= 0;
      for (int k = 0; k < 64; k++) sram[k] <= '0;
    end else begin
      if (psel && penable && !pready_r) begin
        rcnt     <= rcnt + 1;
        pready_r <= (mode != 1) && (rcnt + 1 >= delay);
      end else begin
        pready_r <= 1'b0;
        rcnt     <= 0;
      end
      if (psel && penable && pready_r && pwrite && mode == 0)
        for (int i = 0; i < 4; i++)
          if (pstb[i]) sram[paddr[7:2]][8*i +: 8] <= pdata[8*i +: 8];
    end
  end

  always_comb begin
    prdata = '0;
    if (pready_r)
      for (int i = 0; i < 4; i++)
        if (pstb[i]) prdata[8*i +: 8] = sram[paddr[7:2]][8*i +: 8];
  end
  assign pready = pready_r;
  assign perr   = pready_r && (mode == 2);

  // Reference byte memory and per-request prediction
  logic [7:0] ref_mem [0:255];

  task automatic model(input logic w, input logic [1:0] sz, input logic u, input logic [7:0] a,
                       input logic [31:0] d, output logic e, output logic [31:0] r,
                       output logic [3:0] stb, output logic [31:0] pd);
    int n, o;
    logic [31:0] v;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    o = int'(a) % 4;
    e = (sz == 2'd3) || (int'(a) % n != 0);
    r = '0; stb = '0; pd = '0; v = '0;
    if (!e) begin
      for (int i = 0; i < n; i++) begin
        stb[o+i] = 1'b1;
        if (w) begin
          ref_mem[int'(a)+i] = d[8*i +: 8];
          pd[8*(o+i) +: 8]   = d[8*i +: 8];
        end else begin
          v = v + (32'(ref_mem[int'(a)+i]) << (8*i));
        end
      end
      if (!w && n < 4 && !u && v >= (32'd1 << (8*n-1))) v = v - (32'd1 << (8*n));
      if (!w) r = v;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic        obs_valid, obs_err, obs_sel, obs_unstable, obs_pwrite, obs_psel_rsp, obs_held;
  logic [31:0] obs_rdata, obs_pdata, obs_paddr;
  logic [3:0]  obs_stb;
  int          obs_lat, obs_acc, obs_setup_at;

  task automatic do_req(input logic w, input logic [1:0] sz, input logic u, input logic [7:0] a,
                        input logic [31:0] d);
    int guard;
    @(negedge pclk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = {24'd0, a}; req_wdata = d;
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge pclk); guard++; end
    @(posedge pclk); #1;
    req_valid = 1'b0;
    obs_lat = 0; obs_acc = 0; obs_sel = 1'b0; obs_setup_at = 0; obs_unstable = 1'b0;
    obs_stb = '0; obs_pdata = '0; obs_paddr = '0; obs_pwrite = 1'b0;
    do begin
      @(negedge pclk);
      obs_lat++;
      if (psel) obs_sel = 1'b1;
      if (psel && !penable) begin
        obs_setup_at = obs_lat; obs_stb = pstb; obs_pdata = pdata; obs_paddr = paddr; obs_pwrite = pwrite;
      end
      if (psel && penable) begin
        obs_acc++;
        if ({pstb, pdata, paddr, pwrite} !== {obs_stb, obs_pdata, obs_paddr, obs_pwrite}) obs_unstable = 1'b1;
      end
    end while (!rsp_valid && obs_lat < 60);
    obs_valid = rsp_valid; obs_err = rsp_err; obs_rdata = rsp_rdata; obs_psel_rsp = psel;
    @(negedge pclk);
    obs_held = rsp_valid && (rsp_rdata === obs_rdata) && (rsp_err === obs_err);
    rsp_ready = 1'b1;
    @(posedge pclk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic check_txn(input string tag, input logic w, input logic e_err, input logic [31:0] e_rd,
                           input logic [3:0] e_stb, input logic [31:0] e_pd, input int e_lat);
    chk({tag, " rsp_valid"}, 32'(obs_valid), 32'd1);
    chk({tag, " rsp_err"}, 32'(obs_err), 32'(e_err));
    chk({tag, " rsp_rdata"}, obs_rdata, e_rd);
    chk({tag, " latency"}, 32'(obs_lat), 32'(e_lat));
    chk({tag, " rsp_held"}, 32'(obs_held), 32'd1);
    if (e_err && e_lat == 1) begin
      chk({tag, " no_psel"}, 32'(obs_sel), 32'd0);
    end else begin
      chk({tag, " setup_at"}, 32'(obs_setup_at), 32'd1);
      chk({tag, " pstb"}, 32'(obs_stb), 32'(e_stb));
      chk({tag, " pwrite"}, 32'(obs_pwrite), 32'(w));
      chk({tag, " stable"}, 32'(obs_unstable), 32'd0);
      chk({tag, " psel_drop"}, 32'(obs_psel_rsp), 32'd0);
      if (w) chk({tag, " pdata"}, obs_pdata, e_pd);
    end
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [7:0]  a;
    logic [31:0] d;
    logic        e;
    logic [31:0] rd;
    logic [3:0]  stb;
    logic [31:0] pd;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic        m_e;
    logic [31:0] m_r, m_pd;
    logic [3:0]  m_stb;
    logic        w, u, flag;
    logic [1:0]  sz;
    logic [7:0]  a;
    logic [31:0] d;
    int          guard;

    vecs[0] = '{1'b1, SZ_WORD, 1'b0, 8'h10, 32'hDEADBEEF, 1'b0, 32'h0,        4'b1111, 32'hDEADBEEF};
    vecs[1] = '{1'b0, SZ_BYTE, 1'b0, 8'h13, 32'h0,        1'b0, 32'hFFFFFFDE, 4'b1000, 32'h0};
    vecs[2] = '{1'b0, SZ_BYTE, 1'b1, 8'h13, 32'h0,        1'b0, 32'h000000DE, 4'b1000, 32'h0};
    vecs[3] = '{1'b1, SZ_HALF, 1'b0, 8'h12, 32'h00001234, 1'b0, 32'h0,        4'b1100, 32'h12340000};
    vecs[4] = '{1'b0, SZ_WORD, 1'b0, 8'h10, 32'h0,        1'b0, 32'h1234BEEF, 4'b1111, 32'h0};
    vecs[5] = '{1'b0, SZ_WORD, 1'b0, 8'h11, 32'h0,        1'b1, 32'h0,        4'b0000, 32'h0};
    vecs[6] = '{1'b1, SZ_BYTE, 1'b0, 8'h21, 32'hFFFFFFA5, 1'b0, 32'h0,        4'b0010, 32'h0000A500};
    vecs[7] = '{1'b0, SZ_HALF, 1'b0, 8'h20, 32'h0,        1'b0, 32'hFFFFA500, 4'b0011, 32'h0};
    vecs[8] = '{1'b0, SZ_RSVD, 1'b0, 8'h20, 32'h0,        1'b1, 32'h0,        4'b0000, 32'h0};

    for (int k = 0; k < 256; k++) ref_mem[k] = 8'h00;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst psel", 32'(psel), 32'd0);
    chk("rst penable", 32'(penable), 32'd0);
    chk("rst pwrite", 32'(pwrite), 32'd0);
    chk("rst paddr", paddr, 32'd0);
    chk("rst pdata", pdata, 32'd0);
    chk("rst pstb", 32'(pstb), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rsp_err", 32'(rsp_err), 32'd0);
    chk("rst rsp_rdata", rsp_rdata, 32'd0);
    @(posedge pclk); #1;
    prst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      do_req(vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a, vecs[i].d);
      model(vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a, vecs[i].d, m_e, m_r, m_stb, m_pd);
      check_txn($sformatf("vec%0d", i), vecs[i].w, vecs[i].e, vecs[i].rd, vecs[i].stb, vecs[i].pd,
                vecs[i].e ? 1 : 4);
    end

    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      u = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a = 8'($urandom_range(0, 255));
      d = $urandom;
      if ($urandom_range(0, 3) != 0) a = (sz == SZ_HALF) ? (a & 8'hFE) : (sz == SZ_WORD) ? (a & 8'hFC) : a;
      delay = $urandom_range(1, 5);
      do_req(w, sz, u, a, d);
      model(w, sz, u, a, d, m_e, m_r, m_stb, m_pd);
      check_txn($sformatf("rnd%0d", i), w, m_e, m_r, m_stb, m_pd, m_e ? 1 : 3 + delay);
    end

    // pready in the last allowed ACCESS cycle still completes normally
    delay = 15;
    do_req(1'b0, SZ_WORD, 1'b0, 8'h10, 32'h0);
    model(1'b0, SZ_WORD, 1'b0, 8'h10, 32'h0, m_e, m_r, m_stb, m_pd);
    check_txn("edge16", 1'b0, 1'b0, m_r, 4'b1111, 32'h0, 18);
    chk("edge16 access_cycles", 32'(obs_acc), 32'd16);

    mode = 1;
    do_req(1'b0, SZ_WORD, 1'b0, 8'h10, 32'h0);
    check_txn("timeout", 1'b0, 1'b1, 32'h0, 4'b1111, 32'h0, 18);
    chk("timeout access_cycles", 32'(obs_acc), 32'd16);

    mode = 2; delay = 1;
    do_req(1'b0, SZ_WORD, 1'b0, 8'h10, 32'h0);
    check_txn("perr", 1'b0, 1'b1, 32'h0, 4'b1111, 32'h0, 4);
    mode = 0;

    // Reset during ACCESS abandons the transfer silently
    @(negedge pclk);
    req_valid = 1'b1; req_write = 1'b0; req_size = SZ_WORD; req_unsigned = 1'b0; req_addr = 32'h10;
    @(posedge pclk); #1;
    req_valid = 1'b0;
    guard = 0;
    do begin @(negedge pclk); guard++; end while (!(psel && penable) && guard < 10);
    chk("mid reached_access", 32'(psel && penable), 32'd1);
    prst = 1'b1;
    for (int k = 0; k < 256; k++) ref_mem[k] = 8'h00;
    @(posedge pclk); #1;
    prst = 1'b0;
    @(negedge pclk);
    chk("mid psel", 32'(psel), 32'd0);
    chk("mid penable", 32'(penable), 32'd0);
    chk("mid req_ready", 32'(req_ready), 32'd1);
    flag = rsp_valid;
    repeat (4) begin @(negedge pclk); flag = flag | rsp_valid; end
    chk("mid no_rsp", 32'(flag), 32'd0);

    do_req(1'b1, SZ_WORD, 1'b0, 8'h40, 32'hCAFEF00D);
    model(1'b1, SZ_WORD, 1'b0, 8'h40, 32'hCAFEF00D, m_e, m_r, m_stb, m_pd);
    check_txn("post_rst_wr", 1'b1, 1'b0, 32'h0, 4'b1111, 32'hCAFEF00D, 4);
    do_req(1'b0, SZ_HALF, 1'b1, 8'h42, 32'h0);
    model(1'b0, SZ_HALF, 1'b1, 8'h42, 32'h0, m_e, m_r, m_stb, m_pd);
    check_txn("post_rst_rd", 1'b0, 1'b0, 32'h0000CAFE, 4'b1100, 32'h0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
